// File: rtl/gen_matrix_ctrl_pkg.sv
// Shared Kyber constants, FSM state encoding and the XOF index-ordering helper
// used by the matrix-generation controller.
package gen_matrix_ctrl_pkg;

    localparam int KYBER_K = 3;
    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int COEF_W  = 12;
    localparam int ADDR_W  = 12;
    localparam int XOF_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        NEXT,
        DONE
    } state_t;

    // Returns {xof_x, xof_y}; the transpose flag swaps which index goes first.
    function automatic logic [2*XOF_W-1:0] xof_pair(
        input logic             tr,
        input logic [XOF_W-1:0] i,
        input logic [XOF_W-1:0] j
    );
        return tr ? {i, j} : {j, i};
    endfunction

endpackage

// File: rtl/gen_matrix_ctrl_watchdog.sv
// Per-entry watchdog: counts enabled cycles and flags the cycle on which the
// TIMEOUT-th enabled cycle is being spent.
module parse_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gen_matrix_ctrl.sv
// Sequences the parse engine over all K*K matrix entries, forwards accepted
// coefficients to RAM and flags count mismatches and per-entry timeouts.
module gen_matrix_ctrl
    import gen_matrix_ctrl_pkg::*;
#(
    parameter int K       = KYBER_K,
    parameter int N       = KYBER_N,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              transpose,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              parse_start,
    output logic [XOF_W-1:0]  xof_x,
    output logic [XOF_W-1:0]  xof_y,
    input  logic              parse_done,
    input  logic              coef_valid,
    input  logic [COEF_W-1:0] coef_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [COEF_W-1:0] mem_wdata
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int ENT_W = $clog2(K * K + 1);

    state_t            state;
    logic              tr_q;
    logic [XOF_W-1:0]  idx_i;
    logic [XOF_W-1:0]  idx_j;
    logic [ENT_W-1:0]  entry_idx;
    logic [CNT_W-1:0]  coef_cnt;

    logic              cnt_full;
    logic              wr_ok;
    logic [CNT_W-1:0]  cnt_after;
    logic              expired;
    logic [XOF_W-1:0]  nxt_i;
    logic [XOF_W-1:0]  nxt_j;
    logic              last_entry;

    parse_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .expired (expired)
    );

    // Writes are a zero-latency pass-through; surplus coefficients are dropped.
    assign cnt_full  = (coef_cnt == CNT_W'(N));
    assign wr_ok     = (state == RUN) && coef_valid && !cnt_full;
    assign cnt_after = coef_cnt + CNT_W'(wr_ok);

    assign mem_we    = wr_ok;
    assign mem_wdata = wr_ok ? coef_in : '0;
    assign mem_addr  = wr_ok ? ADDR_W'(int'(entry_idx) * N + int'(coef_cnt)) : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nxt_i      = idx_i;
        nxt_j      = idx_j + 1'b1;
        last_entry = 1'b0;
        if (idx_j == XOF_W'(K - 1)) begin
            nxt_j      = '0;
            nxt_i      = idx_i + 1'b1;
            last_entry = (idx_i == XOF_W'(K - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tr_q        <= 1'b0;
            idx_i       <= '0;
            idx_j       <= '0;
            entry_idx   <= '0;
            coef_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            parse_start <= 1'b0;
            xof_x       <= '0;
            xof_y       <= '0;
        end else begin
            done        <= 1'b0;
            parse_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= LAUNCH;
                        busy           <= 1'b1;
                        error          <= 1'b0;
                        tr_q           <= transpose;
                        idx_i          <= '0;
                        idx_j          <= '0;
                        entry_idx      <= '0;
                        coef_cnt       <= '0;
                        parse_start    <= 1'b1;
                        {xof_x, xof_y} <= xof_pair(transpose, '0, '0);
                    end
                end
                LAUNCH: state <= RUN;
                RUN: begin
                    coef_cnt <= cnt_after;
                    if (coef_valid && cnt_full) error <= 1'b1;
                    // A completed entry wins over a watchdog expiring in the same cycle.
                    if (parse_done) begin
                        state <= NEXT;
                        if (cnt_after != CNT_W'(N)) error <= 1'b1;
                    end else if (expired) begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end
                NEXT: begin
                    coef_cnt  <= '0;
                    idx_i     <= nxt_i;
                    idx_j     <= nxt_j;
                    entry_idx <= entry_idx + 1'b1;
                    if (last_entry) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state          <= LAUNCH;
                        parse_start    <= 1'b1;
                        {xof_x, xof_y} <= xof_pair(tr_q, nxt_i, nxt_j);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
